// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: converts a valid/ready CPU request into an APB
// SETUP/ACCESS transfer and returns a one-cycle response pulse with optional timeout abort.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned STRB_W  = DATA_W / 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept, finish, abort, cnt_inc, timeout_hit;

  assign req_ready   = (state == IDLE);
  assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_W'(TO_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // pready on the expiry edge is checked first so normal completion wins over abort.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (pready) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        psel    <= 1'b1;
        penable <= 1'b0;
        pwrite  <= req_write;
        paddr   <= req_addr & ALIGN_MASK;
        pwdata  <= req_write ? req_wdata : '0;
        pstrb   <= req_write ? req_wstrb : '0;
      end
      if (state == SETUP) begin
        penable <= 1'b1;
        cnt     <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (finish || abort) begin
        psel       <= 1'b0;
        penable    <= 1'b0;
        resp_valid <= 1'b1;
        resp_err   <= abort | pslverr;
        resp_rdata <= (finish && !pwrite && !pslverr) ? prdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge (TIMEOUT=4) against a
// transaction-level model of latency, alignment, strobes, error and timeout rules.
module tb_apb_master_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_rdata = '0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .STRB_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transfer; called at a negedge with the bridge idle, returns at the negedge
  // of the response cycle so the caller may chain the next request immediately.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int unsigned waits, input bit serr,
                      input logic [31:0] rd);
    logic [31:0] ea, ewd, erd;
    logic [3:0]  es;
    bit          tmo, done, eerr;
    int unsigned k;
    ea   = addr & 32'hFFFF_FFFC;
    ewd  = wr ? wdata : 32'h0;
    es   = wr ? strb : 4'h0;
    tmo  = (waits >= TO);
    eerr = tmo ? 1'b1 : serr;
    erd  = (tmo || wr || serr) ? 32'h0 : rd;

    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    @(posedge clk); @(negedge clk);
    req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    check_eq("setup_sel_en", {psel, penable}, 2'b10);
    check_eq("setup_ready", req_ready, 0);
    check_eq("setup_pwrite", pwrite, wr);
    check_eq("setup_paddr", paddr, ea);
    check_eq("setup_pwdata", pwdata, ewd);
    check_eq("setup_pstrb", pstrb, es);
    check_eq("setup_resp_valid", resp_valid, 0);

    k = 0; done = 1'b0;
    while (!done) begin
      @(posedge clk); @(negedge clk);
      check_eq("access_sel_en", {psel, penable}, 2'b11);
      check_eq("access_paddr", paddr, ea);
      check_eq("access_pwrite", pwrite, wr);
      check_eq("access_pwdata", pwdata, ewd);
      check_eq("access_pstrb", pstrb, es);
      check_eq("access_resp_valid", resp_valid, 0);
      if (k == waits) begin
        pready = 1'b1; pslverr = serr; prdata = rd; done = 1'b1;
      end else begin
        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
        if (k == TO - 1) done = 1'b1;
      end
      k++;
    end

    @(posedge clk); @(negedge clk);
    pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
    req_valid = 1'b0;
    check_eq("resp_sel_en", {psel, penable}, 2'b00);
    check_eq("resp_valid", resp_valid, 1);
    check_eq("resp_err", resp_err, eerr);
    check_eq("resp_rdata", resp_rdata, erd);
    check_eq("resp_req_ready", req_ready, 1);
    last_rdata = erd;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom);
    @(posedge clk); @(negedge clk);
    check_eq("idle_resp_valid", resp_valid, 0);
    check_eq("idle_rdata_hold", resp_rdata, last_rdata);
    check_eq("idle_psel", psel, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check_eq("rst_outputs", {psel, penable, pwrite, paddr, pwdata, pstrb}, '0);
    check_eq("rst_resp", {resp_valid, resp_err, resp_rdata}, '0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);

    // Directed scenarios
    xfer(1'b1, 32'h0, 32'h0000_0AF1, 4'hF, 0, 1'b0, 32'h0);
    idle_cycle();
    xfer(1'b0, 32'hC, 32'h0, 4'hF, 1, 1'b0, 32'h5A);
    idle_cycle();
    xfer(1'b1, 32'h6, 32'h1234_5678, 4'h3, 0, 1'b1, 32'h0);
    idle_cycle();
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 50, 1'b0, 32'hDEAD);
    idle_cycle();
    xfer(1'b0, 32'h10, 32'h0, 4'h0, TO - 1, 1'b0, 32'hBEEF);
    idle_cycle();
    xfer(1'b1, 32'h20, 32'hFFFF_0000, 4'h0, 2, 1'b0, 32'h0);
    idle_cycle();
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, 32'h1111);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0, 32'h2222);
    idle_cycle();

    // Randomized transfers, some chained back-to-back
    for (int i = 0; i < 60; i++) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 6),
           ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 2) != 0) idle_cycle();
    end
    idle_cycle();

    // Asynchronous reset in the middle of ACCESS
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; pready = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("pre_rst_access", {psel, penable}, 2'b11);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_sel_en", {psel, penable}, 2'b00);
    check_eq("async_rst_ready", req_ready, 1);
    check_eq("async_rst_resp", resp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    last_rdata = 32'h0;
    check_eq("rel_req_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_eq("post_rst_no_resp", resp_valid, 0);
      check_eq("post_rst_ready", req_ready, 1);
      check_eq("post_rst_psel", psel, 0);
    end
    xfer(1'b0, 32'h30, 32'h0, 4'h0, 1, 1'b0, 32'hCAFE_F00D);
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
